control_unit: RTL and testbench

//  Instruction sequencer for the 8-bit datapath; drives the ALU and registers from program memory.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/control_unit_if.sv | 20 ++
 rtl/control_unit_decode.sv | 37 +++
 rtl/control_unit.sv | 76 +++++++
 tb/tb_control_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: instruction classes, field positions and FSM encoding for the control unit
package ctrl_pkg;
    localparam int INSTR_WIDTH = 16;
    localparam int CLS_MSB = 15;
    localparam int CLS_LSB = 12;
    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] CLASS_NOP     = 4'h0;
    localparam logic [3:0] CLASS_ALU_IMM = 4'h1;
    localparam logic [3:0] CLASS_ALU_EXT = 4'h2;
    localparam logic [3:0] CLASS_MOV     = 4'h3;
    localparam logic [3:0] CLASS_JMP     = 4'h4;
    localparam logic [3:0] CLASS_JZ      = 4'h5;
    localparam logic [3:0] CLASS_JNZ     = 4'h6;
    localparam logic [3:0] CLASS_HALT    = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    function automatic logic is_alu(input logic [3:0] cls);
        return cls == CLASS_ALU_IMM || cls == CLASS_ALU_EXT;
    endfunction
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: ROM/ALU/datapath side signals of the control unit
interface control_unit_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4,
    parameter int PC_WIDTH   = 8
);
    import ctrl_pkg::*;
    logic                   START;
    logic [INSTR_WIDTH-1:0] INSTR;
    logic                   ZF;
    logic [PC_WIDTH-1:0]    PC;
    logic [OP_WIDTH-1:0]    OP;
    logic [DATA_WIDTH-1:0]  IMM;
    logic                   SEL_IN0;
    logic                   CE_ACC;
    logic                   CE_R0;
    logic                   HALTED;
    modport master (input START, INSTR, ZF, output PC, OP, IMM, SEL_IN0, CE_ACC, CE_R0, HALTED);
    modport slave  (output START, INSTR, ZF, input PC, OP, IMM, SEL_IN0, CE_ACC, CE_R0, HALTED);
endinterface

// File: rtl/control_unit_decode.sv
// control_decode: combinational decode of the instruction register into datapath controls
module control_decode
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4
) (
    input  logic [INSTR_WIDTH-1:0] ir_i,
    input  state_t                 state_i,
    input  logic                   zf_q_i,
    output logic [OP_WIDTH-1:0]    op_o,
    output logic [DATA_WIDTH-1:0]  imm_o,
    output logic                   sel_in0_o,
    output logic                   ce_acc_o,
    output logic                   ce_r0_o,
    output logic                   is_jump_o,
    output logic                   jump_taken_o
);
    logic [3:0] cls;
    logic       exec;
    logic       alu;

    assign cls  = ir_i[CLS_MSB:CLS_LSB];
    assign exec = state_i == ST_EXEC;
    assign alu  = exec && is_alu(cls);

    // Controls are only live during EXEC; every other state presents an all-zero word
    always_comb begin
        op_o         = alu ? OP_WIDTH'(ir_i[OP_MSB:OP_LSB]) : '0;
        imm_o        = alu ? DATA_WIDTH'(ir_i[IMM_MSB:IMM_LSB]) : '0;
        sel_in0_o    = exec && cls == CLASS_ALU_IMM;
        ce_acc_o     = alu;
        ce_r0_o      = exec && cls == CLASS_MOV;
        is_jump_o    = cls == CLASS_JMP || cls == CLASS_JZ || cls == CLASS_JNZ;
        jump_taken_o = exec && (cls == CLASS_JMP || (cls == CLASS_JZ && zf_q_i) || (cls == CLASS_JNZ && !zf_q_i));
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: two-cycle fetch/execute sequencer driving the 8-bit ALU datapath
module control_unit
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4,
    parameter int PC_WIDTH   = 8
) (
    input  logic            CLK,
    input  logic            RST,
    control_unit_if.master  bus
);
    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   zf_q, zf_d;
    logic                   is_jump;
    logic                   jump_taken;
    logic [3:0]             cls;

    assign cls        = ir_q[CLS_MSB:CLS_LSB];
    assign bus.PC     = pc_q;
    assign bus.HALTED = state_q == ST_HALT;

    control_decode #(.DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH)) u_decode (
        .ir_i         (ir_q),
        .state_i      (state_q),
        .zf_q_i       (zf_q),
        .op_o         (bus.OP),
        .imm_o        (bus.IMM),
        .sel_in0_o    (bus.SEL_IN0),
        .ce_acc_o     (bus.CE_ACC),
        .ce_r0_o      (bus.CE_R0),
        .is_jump_o    (is_jump),
        .jump_taken_o (jump_taken)
    );

    // Next state: latch IR leaving FETCH; update PC and the latched zero flag leaving EXEC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        zf_d    = zf_q;
        case (state_q)
            ST_IDLE:  state_d = bus.START ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                state_d = ST_EXEC;
                ir_d    = bus.INSTR;
            end
            ST_EXEC:  begin
                state_d = cls == CLASS_HALT ? ST_HALT : ST_FETCH;
                pc_d    = jump_taken ? PC_WIDTH'(ir_q[IMM_MSB:IMM_LSB]) :
                          cls == CLASS_HALT ? pc_q : pc_q + PC_WIDTH'(1);
                zf_d    = is_alu(cls) ? bus.ZF : zf_q;
            end
            default:  state_d = ST_HALT;
        endcase
    end

    // State registers; reset clears them at once so the enables drop within the cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            zf_q    <= zf_d;
        end
    end

    a_taken_is_jump: assert property (@(posedge CLK) disable iff (RST) jump_taken |-> is_jump);
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: ISA-level reference model and scoreboard around the control unit with a small ALU datapath
module tb_control_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] op;
        logic [7:0] imm;
        logic       sel;
        logic       ce_acc;
        logic       ce_r0;
        logic       halted;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rom [256];
    logic [7:0]  ext = 8'h00;
    logic [7:0]  acc = 8'h00;
    logic [7:0]  r0  = 8'h00;
    logic [7:0]  in0;
    rec_t        exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    control_unit_if #(.DATA_WIDTH(8), .OP_WIDTH(4), .PC_WIDTH(8)) bus ();
    control_unit #(.DATA_WIDTH(8), .OP_WIDTH(4), .PC_WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus));

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd1: return b + a;
            4'd2: return b - a;
            4'd3: return b & a;
            4'd4: return b | a;
            4'd5: return b ^ a;
            4'd6: return ~b;
            default: return a;
        endcase
    endfunction

    assign bus.INSTR = rom[bus.PC];
    assign in0       = bus.SEL_IN0 ? bus.IMM : ext;
    assign bus.ZF    = alu(bus.OP, in0, acc) == 8'h00;

    always @(posedge clk) begin
        if (bus.CE_ACC) acc <= alu(bus.OP, in0, acc);
        if (bus.CE_R0) r0 <= acc;
    end

    initial begin : monitor
        rec_t e, a;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{bus.PC, bus.OP, bus.IMM, bus.SEL_IN0, bus.CE_ACC, bus.CE_R0, bus.HALTED};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL seq t=%0t got pc=%h op=%h imm=%h sel=%b cea=%b cer=%b halt=%b want pc=%h op=%h imm=%h sel=%b cea=%b cer=%b halt=%b",
                             $time, a.pc, a.op, a.imm, a.sel, a.ce_acc, a.ce_r0, a.halted,
                             e.pc, e.op, e.imm, e.sel, e.ce_acc, e.ce_r0, e.halted);
                end
            end
        end
    end

    // Interprets the program one instruction at a time and queues the per-cycle output words
    task automatic model_run(input int max_instr, output bit halted, output logic [7:0] acc_o, output logic [7:0] r0_o);
        logic [7:0]  pc = 8'h00;
        logic [7:0]  a = acc;
        logic [7:0]  r = r0;
        logic [7:0]  res;
        bit          z = 1'b0;
        bit          alu_c;
        bit          taken;
        logic [15:0] ins;
        logic [3:0]  cls;
        halted = 1'b0;
        for (int i = 0; i < max_instr; i++) begin
            ins   = rom[pc];
            cls   = ins[15:12];
            alu_c = cls == 4'h1 || cls == 4'h2;
            exp_q.push_back('{pc, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
            exp_q.push_back('{pc, alu_c ? ins[11:8] : 4'h0, alu_c ? ins[7:0] : 8'h00,
                              cls == 4'h1, alu_c, cls == 4'h3, 1'b0});
            if (alu_c) begin
                res = alu(ins[11:8], cls == 4'h1 ? ins[7:0] : ext, a);
                z   = res == 8'h00;
                a   = res;
            end else if (cls == 4'h3) r = a;
            if (cls == 4'hF) begin
                repeat (10) exp_q.push_back('{pc, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
                halted = 1'b1;
                break;
            end
            taken = cls == 4'h4 || (cls == 4'h5 && z) || (cls == 4'h6 && !z);
            pc    = taken ? ins[7:0] : pc + 8'd1;
        end
        acc_o = a;
        r0_o  = r;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) exp_q.push_back('0);
        repeat (10) @(negedge clk);
    endtask

    task automatic run(input int max_instr);
        bit         h;
        logic [7:0] ea, er;
        int         guard = 0;
        do_reset();
        model_run(max_instr, h, ea, er);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (5) @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        if (h) begin
            checks++;
            if (acc !== ea || r0 !== er) begin
                failures++;
                $display("FAIL datapath got acc=%h r0=%h want acc=%h r0=%h", acc, r0, ea, er);
            end
        end
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 256; i++) rom[i] = v;
    endtask

    task automatic rand_rom();
        int          k;
        logic [3:0]  cls;
        for (int i = 0; i < 256; i++) begin
            k   = $urandom_range(0, 99);
            cls = k < 20 ? 4'h1 : k < 35 ? 4'h2 : k < 45 ? 4'h3 : k < 55 ? 4'h4 :
                  k < 65 ? 4'h5 : k < 75 ? 4'h6 : k < 85 ? 4'h0 : k < 92 ? 4'(7 + $urandom_range(0, 6)) : 4'hF;
            rom[i] = {cls, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
        end
        ext = 8'($urandom_range(0, 255));
    endtask

    task automatic reset_mid_exec();
        logic [7:0] acc_before;
        rst = 1'b1;
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fill_rom(16'hF000);
        rom[0] = 16'h1177;
        acc_before = acc;
        @(negedge clk);
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (bus.CE_ACC !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got ce_acc=%b want 1", bus.CE_ACC);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.CE_ACC, bus.CE_R0, bus.OP, bus.PC, bus.HALTED} !== '0) begin
            failures++;
            $display("FAIL rst_async got cea=%b cer=%b op=%h pc=%h halt=%b want all 0",
                     bus.CE_ACC, bus.CE_R0, bus.OP, bus.PC, bus.HALTED);
        end
        @(posedge clk);
        #1;
        checks++;
        if (acc !== acc_before) begin
            failures++;
            $display("FAIL rst_acc got acc=%h want %h", acc, acc_before);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.START = 1'b0;
        fill_rom(16'hF000);
        rom[0] = 16'h1A23;
        rom[1] = 16'h3000;
        rom[2] = 16'h2500;
        rom[3] = 16'hF000;
        ext = 8'h5C;
        run(20);
        fill_rom(16'hF000);
        rom[8'h00] = 16'h4010;
        rom[8'h10] = 16'h1000;
        rom[8'h11] = 16'h0000;
        rom[8'h12] = 16'h5040;
        rom[8'h40] = 16'h6050;
        rom[8'h41] = 16'h1001;
        rom[8'h42] = 16'h5010;
        rom[8'h43] = 16'h6060;
        rom[8'h60] = 16'h40FF;
        rom[8'hFF] = 16'h0000;
        run(16);
        fill_rom(16'hF000);
        rom[0] = 16'h4000;
        run(6);
        reset_mid_exec();
        for (int n = 0; n < 20; n++) begin
            rand_rom();
            run(30);
        end
        reset_mid_exec();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
